// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one bus request at a time, buffers the
// returned word and hands it to decode, discarding responses overtaken by a redirect.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign,
  input  logic        if_ready
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    KILL  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [63:0] r_req_pc;
  logic [63:0] r_pend_pc;
  logic [31:0] r_buf_instr;
  logic        r_buf_mis;
  logic        w_aligned;

  assign w_aligned = (r_req_pc[1:0] == 2'b00);

  // NOTE: every register is written with <= so all next-state values are
  // computed from the same pre-edge snapshot, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FETCH;
      r_req_pc    <= RESET_PC;
      r_pend_pc   <= '0;
      r_buf_instr <= '0;
      r_buf_mis   <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (!w_aligned) begin
            // No request goes out for a misaligned PC; present it as a faulting slot.
            if (redirect_valid) begin
              r_req_pc <= redirect_pc;
            end else begin
              r_buf_instr <= '0;
              r_buf_mis   <= 1'b1;
              r_state     <= HOLD;
            end
          end else if (iresp_data_ok) begin
            if (redirect_valid) begin
              r_req_pc <= redirect_pc;
            end else begin
              r_buf_instr <= iresp_data;
              r_buf_mis   <= 1'b0;
              r_state     <= HOLD;
            end
          end else if (redirect_valid) begin
            r_pend_pc <= redirect_pc;
            r_state   <= KILL;
          end
        end
        KILL: begin
          // The stale request must still complete before the new target is issued.
          if (iresp_data_ok) begin
            r_req_pc <= redirect_valid ? redirect_pc : r_pend_pc;
            r_state  <= FETCH;
          end else if (redirect_valid) begin
            r_pend_pc <= redirect_pc;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            r_req_pc <= redirect_pc;
            r_state  <= FETCH;
          end else if (if_ready) begin
            r_req_pc <= r_req_pc + 64'd4;
            r_state  <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  // Reset gates the request and presentation strobes so they drop immediately.
  assign ireq_valid  = reset & (((r_state == FETCH) & w_aligned) | (r_state == KILL));
  assign ireq_addr   = r_req_pc;
  assign if_valid    = reset & (r_state == HOLD) & ~redirect_valid;
  assign if_pc       = r_req_pc;
  assign if_instr    = r_buf_instr;
  assign if_misalign = reset & (r_state == HOLD) & r_buf_mis;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: hand-computed expectations for fetch, kill,
// hold, misalignment, PC wrap and asynchronous reset.
module tb_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;
  logic        if_ready;

  int n_vec;
  int n_err;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_misalign   (if_misalign),
    .if_ready      (if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [63:0] rpc, input logic ok,
                       input logic [31:0] data, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    iresp_data_ok  = ok;
    iresp_data     = data;
    if_ready       = rdy;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("rst_ireq_valid", {63'h0, ireq_valid}, 64'd0);
    check("rst_if_valid", {63'h0, if_valid}, 64'd0);
    check("rst_if_mis", {63'h0, if_misalign}, 64'd0);
    tick();
    tick();
    check("rst_ireq_valid_clk", {63'h0, ireq_valid}, 64'd0);

    // Cycle 1 after release: first fetch at RESET_PC.
    reset = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    check("c1_ireq_valid", {63'h0, ireq_valid}, 64'd1);
    check("c1_ireq_addr", ireq_addr, RESET_PC);
    check("c1_if_valid", {63'h0, if_valid}, 64'd0);
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'h0000_0013, 1'b0);
    check("c2_ireq_addr", ireq_addr, RESET_PC);
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    check("c3_if_valid", {63'h0, if_valid}, 64'd1);
    check("c3_if_pc", if_pc, 64'h8000_0000);
    check("c3_if_instr", {32'h0, if_instr}, 64'h13);
    check("c3_ireq_valid", {63'h0, ireq_valid}, 64'd0);
    tick();
    // Next sequential fetch, then redirect before the response.
    drive(1'b1, 64'h8000_0100, 1'b0, 32'h0, 1'b0);
    check("seq_addr", ireq_addr, 64'h8000_0004);
    check("seq_valid", {63'h0, ireq_valid}, 64'd1);
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    check("kill_addr_stable", ireq_addr, 64'h8000_0004);
    check("kill_valid", {63'h0, ireq_valid}, 64'd1);
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check("kill_no_present", {63'h0, if_valid}, 64'd0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    check("redir_addr", ireq_addr, 64'h8000_0100);
    check("redir_if_valid", {63'h0, if_valid}, 64'd0);
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'h0010_0093, 1'b0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    check("hold_if_valid", {63'h0, if_valid}, 64'd1);
    check("hold_if_instr", {32'h0, if_instr}, 64'h0010_0093);
    check("hold_if_pc", if_pc, 64'h8000_0100);

    // Stall for five cycles; stray data_ok must be ignored.
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(1'b0, 64'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      check("stall_if_valid", {63'h0, if_valid}, 64'd1);
      check("stall_if_pc", if_pc, 64'h8000_0100);
      check("stall_if_instr", {32'h0, if_instr}, 64'h0010_0093);
      check("stall_ireq_valid", {63'h0, ireq_valid}, 64'd0);
    end
    tick();
    drive(1'b1, 64'h8000_0200, 1'b0, 32'h0, 1'b1);
    check("drop_if_valid", {63'h0, if_valid}, 64'd0);
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'h0000_0013, 1'b0);
    check("drop_addr", ireq_addr, 64'h8000_0200);
    check("drop_valid", {63'h0, ireq_valid}, 64'd1);

    // Misaligned redirect from HOLD.
    tick();
    drive(1'b1, 64'h8000_0102, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'hAAAA_5555, 1'b0);
    check("mis_no_req", {63'h0, ireq_valid}, 64'd0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    check("mis_if_valid", {63'h0, if_valid}, 64'd1);
    check("mis_flag", {63'h0, if_misalign}, 64'd1);
    check("mis_pc", if_pc, 64'h8000_0102);
    check("mis_instr", {32'h0, if_instr}, 64'h0);

    // PC wrap at the top of the address space.
    tick();
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'h0000_0013, 1'b0);
    check("top_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    check("top_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("top_if_mis", {63'h0, if_misalign}, 64'd0);
    tick();
    // Response and redirect in the same FETCH cycle: response discarded.
    drive(1'b1, 64'h8000_0600, 1'b1, 32'h1234_5678, 1'b0);
    check("wrap_addr", ireq_addr, 64'h0);
    check("wrap_valid", {63'h0, ireq_valid}, 64'd1);
    tick();
    drive(1'b1, 64'h8000_0300, 1'b0, 32'h0, 1'b0);
    check("same_cyc_addr", ireq_addr, 64'h8000_0600);
    check("same_cyc_if_valid", {63'h0, if_valid}, 64'd0);

    // Two redirects while killing: the last one wins.
    tick();
    drive(1'b1, 64'h8000_0400, 1'b0, 32'h0, 1'b0);
    check("k2_addr", ireq_addr, 64'h8000_0600);
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'h0BAD_0BAD, 1'b0);
    check("k2_addr_hold", ireq_addr, 64'h8000_0600);
    tick();
    drive(1'b1, 64'h8000_0700, 1'b0, 32'h0, 1'b0);
    check("k2_last_wins", ireq_addr, 64'h8000_0400);

    // Asynchronous reset in the middle of a KILL.
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    check("pre_rst_valid", {63'h0, ireq_valid}, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check("arst_ireq_valid", {63'h0, ireq_valid}, 64'd0);
    check("arst_if_valid", {63'h0, if_valid}, 64'd0);
    check("arst_if_mis", {63'h0, if_misalign}, 64'd0);
    check("arst_addr", ireq_addr, RESET_PC);
    tick();
    tick();
    reset = 1'b1;
    drive(1'b0, 64'h0, 1'b1, 32'h0000_0013, 1'b0);
    check("rel_addr", ireq_addr, RESET_PC);
    check("rel_valid", {63'h0, ireq_valid}, 64'd1);
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    check("rel_if_valid", {63'h0, if_valid}, 64'd1);
    check("rel_if_pc", if_pc, RESET_PC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
